// File: rtl/sht40_measure_ctrl.sv
// sht40_measure_ctrl
// Sequences one SHT40 temperature/humidity measurement over an external I2C
// byte engine. It writes the measure command, waits for the conversion to
// complete, and reads six bytes. Each 16-bit word in those bytes is checked
// with the sensor CRC-8 before the raw results are published. A NACKed read
// is retried up to MAX_RETRY times.
//
// Ports
//   clk            single clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   meas_trig      one-cycle measurement request (ignored while busy)
//   i2c_start_req  one-cycle pulse launching an engine transaction
//   i2c_addr       7-bit sensor address (DEV_ADDR)
//   i2c_rw         0 write / 1 read, held from start until the engine finishes
//   i2c_tx_data    command byte for the write transaction
//   sht_reads      byte count of the transaction (1 write, 6 read)
//   i2c_busy       engine active
//   i2c_done       one-cycle end-of-transaction pulse
//   i2c_nack       NACK status, qualified by i2c_done
//   i2c_rx_valid   one received byte on i2c_rx_data
//   temp_raw       last good raw temperature word
//   hum_raw        last good raw humidity word
//   data_valid     one-cycle pulse when temp_raw/hum_raw update
//   busy           controller active
//   crc_err        sticky CRC failure of the last measurement
//   nack_err       sticky NACK / short-read failure of the last measurement
module sht40_measure_ctrl #(
  parameter logic [6:0] DEV_ADDR    = 7'h44,
  parameter logic [7:0] CMD_BYTE    = 8'hFD,
  parameter int         WAIT_CYCLES = 500000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_trig,
  output logic        i2c_start_req,
  output logic [6:0]  i2c_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_tx_data,
  output logic [3:0]  sht_reads,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic        i2c_rx_valid,
  input  logic [7:0]  i2c_rx_data,
  output logic [15:0] temp_raw,
  output logic [15:0] hum_raw,
  output logic        data_valid,
  output logic        busy,
  output logic        crc_err,
  output logic        nack_err
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    WAIT_CMD  = 3'd2,
    MEAS_WAIT = 3'd3,
    SEND_RD   = 3'd4,
    WAIT_RD   = 3'd5,
    CHECK     = 3'd6,
    DONE      = 3'd7
  } state_t;

  // Sensirion CRC-8: poly 0x31, init 0xFF, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_word(input logic [7:0] msb, input logic [7:0] lsb);
    logic [7:0]  crc;
    logic [15:0] data;
    crc  = 8'hFF;
    data = {msb, lsb};
    for (int i = 15; i >= 0; i--) begin
      if (crc[7] ^ data[i]) begin
        crc = {crc[6:0], 1'b0} ^ 8'h31;
      end else begin
        crc = {crc[6:0], 1'b0};
      end
    end
    return crc;
  endfunction

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic [RTY_W-1:0]  retry_r;
  logic [2:0]        rx_idx_r, rx_idx_eff_s;
  logic [5:0][7:0]   rx_bytes_r;
  logic              rx_store_s, crc_ok_s, accept_s;
  logic              start_req_r, rw_r, data_valid_r, busy_r, crc_err_r, nack_err_r;
  logic [7:0]        tx_data_r;
  logic [3:0]        reads_r;
  logic [15:0]       temp_r, hum_r;

  // Next-state logic plus the receive/CRC qualifiers it depends on.
  always_comb begin
    state_next_s = state_r;
    rx_store_s   = (state_r == WAIT_RD) && i2c_rx_valid && (rx_idx_r < 3'd6);
    // A byte arriving with i2c_done counts toward the completeness check.
    rx_idx_eff_s = rx_store_s ? (rx_idx_r + 3'd1) : rx_idx_r;
    crc_ok_s     = (crc8_word(rx_bytes_r[0], rx_bytes_r[1]) == rx_bytes_r[2]) &&
                   (crc8_word(rx_bytes_r[3], rx_bytes_r[4]) == rx_bytes_r[5]);
    accept_s     = (state_r == IDLE) && meas_trig && !i2c_busy;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = SEND_CMD;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND_CMD: state_next_s = WAIT_CMD;
      WAIT_CMD: begin
        if (i2c_done) begin
          if (i2c_nack) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = MEAS_WAIT;
          end
        end else begin
          state_next_s = WAIT_CMD;
        end
      end
      MEAS_WAIT: begin
        if (wait_cnt_r == CNT_LAST) begin
          state_next_s = SEND_RD;
        end else begin
          state_next_s = MEAS_WAIT;
        end
      end
      SEND_RD: state_next_s = WAIT_RD;
      WAIT_RD: begin
        if (i2c_done) begin
          if (i2c_nack) begin
            if (retry_r < RTY_MAX) begin
              state_next_s = MEAS_WAIT;
            end else begin
              state_next_s = IDLE;
            end
          end else if (rx_idx_eff_s == 3'd6) begin
            state_next_s = CHECK;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = WAIT_RD;
        end
      end
      CHECK: begin
        if (crc_ok_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_req_r  <= 1'b0;
      rw_r         <= 1'b0;
      tx_data_r    <= 8'h00;
      reads_r      <= 4'd0;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      start_req_r  <= (state_next_s == SEND_CMD) || (state_next_s == SEND_RD);
      data_valid_r <= (state_next_s == DONE);
      busy_r       <= (state_next_s != IDLE);
      // rw and sht_reads stay put between launches so they are stable through i2c_done.
      if (state_next_s == SEND_CMD) begin
        rw_r      <= 1'b0;
        tx_data_r <= CMD_BYTE;
        reads_r   <= 4'd1;
      end else if (state_next_s == SEND_RD) begin
        rw_r      <= 1'b1;
        tx_data_r <= 8'h00;
        reads_r   <= 4'd6;
      end
    end
  end

  // Wait counter, retry counter and receive byte store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
      retry_r    <= '0;
      rx_idx_r   <= 3'd0;
      rx_bytes_r <= '0;
    end else begin
      if (state_r != MEAS_WAIT) begin
        wait_cnt_r <= '0;
      end else if (wait_cnt_r != CNT_LAST) begin
        wait_cnt_r <= wait_cnt_r + 1'b1;
      end
      if (accept_s || (state_r == DONE)) begin
        retry_r <= '0;
      end else if ((state_r == WAIT_RD) && i2c_done && i2c_nack && (retry_r < RTY_MAX)) begin
        retry_r <= retry_r + 1'b1;
      end
      if (state_r == SEND_RD) begin
        rx_idx_r <= 3'd0;
      end else if (rx_store_s) begin
        rx_idx_r             <= rx_idx_r + 3'd1;
        rx_bytes_r[rx_idx_r] <= i2c_rx_data;
      end
    end
  end

  // Result words and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_r     <= 16'h0000;
      hum_r      <= 16'h0000;
      crc_err_r  <= 1'b0;
      nack_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        crc_err_r  <= 1'b0;
        nack_err_r <= 1'b0;
      end else begin
        if ((state_r == CHECK) && !crc_ok_s) begin
          crc_err_r <= 1'b1;
        end
        // Every exit from a transfer-wait state straight to IDLE is a NACK or short read.
        if (((state_r == WAIT_CMD) || (state_r == WAIT_RD)) && (state_next_s == IDLE)) begin
          nack_err_r <= 1'b1;
        end
      end
      if ((state_r == CHECK) && crc_ok_s) begin
        temp_r <= {rx_bytes_r[0], rx_bytes_r[1]};
        hum_r  <= {rx_bytes_r[3], rx_bytes_r[4]};
      end
    end
  end

  assign i2c_start_req = start_req_r;
  assign i2c_addr      = DEV_ADDR;
  assign i2c_rw        = rw_r;
  assign i2c_tx_data   = tx_data_r;
  assign sht_reads     = reads_r;
  assign temp_raw      = temp_r;
  assign hum_raw       = hum_r;
  assign data_valid    = data_valid_r;
  assign busy          = busy_r;
  assign crc_err       = crc_err_r;
  assign nack_err      = nack_err_r;

endmodule

// File: tb/tb_sht40_measure_ctrl.sv
// Scoreboard bench for sht40_measure_ctrl (WAIT_CYCLES=20, MAX_RETRY=2).
// Stimulus pushes the expected engine launches and result pulses into a queue.
// A negedge monitor pops one entry per i2c_start_req or data_valid and compares it.
module tb_sht40_measure_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        meas_trig, i2c_busy, i2c_done, i2c_nack, i2c_rx_valid;
  logic [7:0]  i2c_rx_data;
  logic        i2c_start_req, i2c_rw, data_valid, busy, crc_err, nack_err;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_tx_data;
  logic [3:0]  sht_reads;
  logic [15:0] temp_raw, hum_raw;

  typedef struct packed {
    logic        kind;   // 0 = engine launch, 1 = data_valid
    logic        rw;
    logic [3:0]  reads;
    logic [15:0] t;
    logic [15:0] h;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  sht40_measure_ctrl #(.WAIT_CYCLES(20), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .meas_trig(meas_trig),
    .i2c_start_req(i2c_start_req), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_tx_data(i2c_tx_data), .sht_reads(sht_reads), .i2c_busy(i2c_busy),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rx_valid(i2c_rx_valid),
    .i2c_rx_data(i2c_rx_data), .temp_raw(temp_raw), .hum_raw(hum_raw),
    .data_valid(data_valid), .busy(busy), .crc_err(crc_err), .nack_err(nack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_start(input logic rw);
    exp_t e;
    e = '{kind: 1'b0, rw: rw, reads: (rw ? 4'd6 : 4'd1), t: 16'h0000, h: 16'h0000};
    sb_q.push_back(e);
  endtask

  task automatic push_data(input logic [15:0] t, input logic [15:0] h);
    exp_t e;
    e = '{kind: 1'b1, rw: 1'b0, reads: 4'd0, t: t, h: h};
    sb_q.push_back(e);
  endtask

  // Monitor: every launch or result pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (i2c_start_req || data_valid)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got start=%0b dv=%0b, expected none", i2c_start_req, data_valid);
      end else begin
        e = sb_q.pop_front();
        check("event_kind", {31'd0, data_valid}, {31'd0, e.kind});
        if (!e.kind) begin
          check("start_rw", {31'd0, i2c_rw}, {31'd0, e.rw});
          check("start_reads", {28'd0, sht_reads}, {28'd0, e.reads});
          check("start_addr", {25'd0, i2c_addr}, 32'h44);
          if (!e.rw) begin
            check("start_cmd", {24'd0, i2c_tx_data}, 32'hFD);
          end
        end else begin
          check("data_words", {temp_raw, hum_raw}, {e.t, e.h});
        end
      end
    end
  end

  task automatic trig();
    meas_trig = 1'b1;
    tick();
    meas_trig = 1'b0;
  endtask

  task automatic finish_txn(input logic nack);
    i2c_done = 1'b1;
    i2c_nack = nack;
    tick();
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
  endtask

  // Cycles until i2c_start_req is seen, then one more so the DUT sits in its wait state.
  task automatic wait_start(output int c);
    c = 0;
    while (!i2c_start_req && c < 100) begin
      tick();
      c++;
    end
    tick();
  endtask

  task automatic rx_seq(input logic [47:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      i2c_rx_valid = 1'b1;
      i2c_rx_data  = b[47 - 8*i -: 8];
      tick();
    end
    i2c_rx_valid = 1'b0;
    i2c_rx_data  = 8'h00;
  endtask

  // Trigger, acknowledge the command write, and land in WAIT_RD.
  task automatic write_phase(input string tag);
    int c;
    push_start(1'b0);
    trig();
    wait_start(c);
    check({tag, "_cmd_latency"}, c, 0);
    push_start(1'b1);
    finish_txn(1'b0);
    wait_start(c);
    check({tag, "_meas_wait"}, c, 20);
  endtask

  localparam logic [47:0] GOOD_A = 48'hBEEF92_666693;  // temp BEEF, hum 6666
  localparam logic [47:0] GOOD_B = 48'h666693_BEEF92;  // temp 6666, hum BEEF
  localparam logic [47:0] BAD_A  = 48'hBEEF93_666693;  // temp CRC wrong

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    rst_n = 1'b0; meas_trig = 1'b0; i2c_busy = 1'b0; i2c_done = 1'b0;
    i2c_nack = 1'b0; i2c_rx_valid = 1'b0; i2c_rx_data = 8'h00;
    repeat (3) tick();
    check("rst_outputs", {i2c_start_req, i2c_rw, data_valid, busy, crc_err, nack_err, sht_reads},
          32'h0);
    check("rst_words", {temp_raw, hum_raw}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Nominal measurement.
    write_phase("nom");
    check("nom_busy", {31'd0, busy}, 32'd1);
    push_data(16'hBEEF, 16'h6666);
    rx_seq(GOOD_A, 6);
    finish_txn(1'b0);
    repeat (3) tick();
    check("nom_flags", {busy, crc_err, nack_err}, 32'd0);

    // CRC failure keeps previous words.
    write_phase("crc");
    rx_seq(BAD_A, 6);
    finish_txn(1'b0);
    repeat (3) tick();
    check("crc_err", {31'd0, crc_err}, 32'd1);
    check("crc_keep", {temp_raw, hum_raw}, 32'hBEEF_6666);

    // Two read NACKs, then success.
    write_phase("rty");
    check("rty_clear_crc", {31'd0, crc_err}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      push_start(1'b1);
      finish_txn(1'b1);
      wait_start(c);
      check("rty_wait", c, 20);
    end
    push_data(16'h6666, 16'hBEEF);
    rx_seq(GOOD_B, 6);
    finish_txn(1'b0);
    repeat (3) tick();
    check("rty_ok_flags", {crc_err, nack_err}, 32'd0);

    // Three read NACKs exhaust the retries.
    write_phase("rtx");
    for (int k = 0; k < 2; k++) begin
      push_start(1'b1);
      finish_txn(1'b1);
      wait_start(c);
    end
    finish_txn(1'b1);
    check("rtx_nack_err", {30'd0, nack_err, busy}, 32'd2);
    repeat (30) tick();

    // Write NACK: no read, idle on the next cycle.
    push_start(1'b0);
    trig();
    wait_start(c);
    finish_txn(1'b1);
    check("wnack", {30'd0, nack_err, busy}, 32'd2);
    repeat (30) tick();

    // Short read: four bytes then done.
    write_phase("short");
    rx_seq(GOOD_A, 4);
    finish_txn(1'b0);
    check("short_nack", {30'd0, nack_err, busy}, 32'd2);
    repeat (3) tick();
    check("short_keep", {temp_raw, hum_raw}, 32'h6666_BEEF);

    // Sixth byte arrives together with done.
    write_phase("same");
    push_data(16'hBEEF, 16'h6666);
    rx_seq(GOOD_A, 5);
    i2c_rx_valid = 1'b1; i2c_rx_data = GOOD_A[7:0];
    finish_txn(1'b0);
    i2c_rx_valid = 1'b0; i2c_rx_data = 8'h00;
    repeat (3) tick();
    check("same_flags", {crc_err, nack_err}, 32'd0);

    // A seventh byte is dropped.
    write_phase("extra");
    push_data(16'h6666, 16'hBEEF);
    rx_seq(GOOD_B, 6);
    rx_seq(48'hAA0000_000000, 1);
    finish_txn(1'b0);
    repeat (3) tick();
    check("extra_flags", {crc_err, nack_err}, 32'd0);

    // Reset in MEAS_WAIT with extra triggers while busy.
    push_start(1'b0);
    trig();
    wait_start(c);
    trig();
    finish_txn(1'b0);
    repeat (4) tick();
    trig();
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {i2c_start_req, i2c_rw, data_valid, busy, crc_err, nack_err,
                              sht_reads, i2c_tx_data}, 32'h0);
    check("mid_rst_words", {temp_raw, hum_raw}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    push_start(1'b0);
    trig();
    wait_start(c);
    check("post_rst_start", c, 0);
    finish_txn(1'b1);
    repeat (3) tick();
    check("post_rst_nack", {31'd0, nack_err}, 32'd1);

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sht40_measure_ctrl.md
SHT40_MEASURE_CTRL -- requirements
Module: sht40_measure_ctrl

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h44, 7-bit I2C sensor address.
REQ-002 SHALL have parameter CMD_BYTE, default 8'hFD, high-precision measure command.
REQ-003 SHALL have parameter WAIT_CYCLES, default 500000, measurement wait in clk cycles (10 ms at 50 MHz).
REQ-004 SHALL have parameter MAX_RETRY, default 3, read retries allowed after NACK.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 Rst_N  in  1  reset, asynchronous, active-low.
REQ-007 Meas_Trig  in  1  one-cycle request for one measurement.
REQ-008 I2c_Start_Req  out  1  one-cycle pulse launching a transaction on the I2C byte engine.
REQ-009 I2c_Addr  out  7  always DEV_ADDR.
REQ-010 I2c_Rw  out  1  0 write, 1 read; held stable from Start_Req until I2c_Done.
REQ-011 I2c_Tx_Data  out  8  write byte; CMD_BYTE during write transaction.
REQ-012 SHT_Reads  out  4  byte count for the transaction: 1 on write, 6 on read.
REQ-013 I2c_Busy  in  1  byte engine active.
REQ-014 I2c_Done  in  1  one-cycle pulse at end of transaction (after stop).
REQ-015 I2c_Nack  in  1  valid with I2c_Done; 1 = address or data NACKed.
REQ-016 I2c_Rx_Valid / I2c_Rx_Data  in  1 / 8  one received byte per Rx_Valid pulse, MSB-first order from sensor.
REQ-017 Temp_Raw / Hum_Raw  out  16 / 16  last good raw words.
REQ-018 Data_Valid  out  1  one-cycle pulse when Temp_Raw/Hum_Raw updated.
REQ-019 Busy, Crc_Err, Nack_Err  out  1 each  controller active; sticky error flags.

Function
REQ-020 States: IDLE, SEND_CMD, WAIT_CMD, MEAS_WAIT, SEND_RD, WAIT_RD, CHECK, DONE.
REQ-021 IDLE: Meas_Trig=1 and I2c_Busy=0 -> SEND_CMD, clear Crc_Err and Nack_Err, Busy=1 next cycle; Meas_Trig while Busy=1 SHALL be ignored.
REQ-022 SEND_CMD: pulse I2c_Start_Req one cycle with Rw=0, SHT_Reads=1 -> WAIT_CMD.
REQ-023 WAIT_CMD: I2c_Done&Nack -> set Nack_Err, IDLE; I2c_Done&!Nack -> MEAS_WAIT, wait counter=0.
REQ-024 MEAS_WAIT: count each cycle; at count WAIT_CYCLES-1 -> SEND_RD; counter width SHALL be $clog2(WAIT_CYCLES+1).
REQ-025 SEND_RD: pulse Start_Req with Rw=1, SHT_Reads=6, byte index=0 -> WAIT_RD.
REQ-026 WAIT_RD: each Rx_Valid stores byte at index 0..5, index increments; Rx_Valid beyond index 5 SHALL be dropped.
REQ-027 WAIT_RD on Done&Nack: retry counter<MAX_RETRY -> increment, MEAS_WAIT; else set Nack_Err, IDLE.
REQ-028 WAIT_RD on Done&!Nack: index!=6 -> set Nack_Err, IDLE; index==6 -> CHECK.
REQ-029 CHECK (one cycle): CRC-8, poly 0x31, init 0xFF, no reflection, no final XOR, over bytes 0-1 vs byte 2 and bytes 3-4 vs byte 5.
REQ-030 Both CRCs match -> Temp_Raw={b0,b1}, Hum_Raw={b3,b4}, DONE; any mismatch -> set Crc_Err, outputs unchanged, IDLE.
REQ-031 DONE: Data_Valid=1 for exactly one cycle, retry counter cleared -> IDLE.
REQ-032 Busy SHALL be 1 in every state except IDLE.
REQ-033 Done and Rx_Valid in same cycle: byte SHALL be stored before the index==6 check.
REQ-034 I2c_Done outside WAIT_CMD/WAIT_RD SHALL be ignored.

Reset
REQ-035 Rst_N=0 SHALL immediately force IDLE, clear all counters, byte store, Temp_Raw=0, Hum_Raw=0, and drive Start_Req, Rw, Tx_Data, SHT_Reads, Data_Valid, Busy, Crc_Err, Nack_Err to 0.
REQ-036 Reset mid-transaction SHALL abandon it without any further Start_Req; first action after release requires new Meas_Trig.

Verification (WAIT_CYCLES=20, MAX_RETRY=2)
REQ-037 Nominal: trig, ack write, read 0xBE,0xEF,0x92,0x66,0x66,0x93 -> Temp_Raw=16'hBEEF, Hum_Raw=16'h6666, one Data_Valid pulse, exactly 20 cycles between write Done and read Start_Req.
REQ-038 CRC fail: same but byte 2=0x93 -> Crc_Err=1, Data_Valid never pulses, Temp_Raw keeps prior value.
REQ-039 Retry: read NACKed twice then good -> three read Start_Req pulses, Data_Valid=1; NACKed three times -> Nack_Err=1, IDLE.
REQ-040 Write NACK: Done with Nack=1 in WAIT_CMD -> Nack_Err=1, no read issued, Busy=0 next cycle.
REQ-041 Short read: Done after 4 Rx_Valid -> Nack_Err=1, outputs unchanged.
REQ-042 Reset in MEAS_WAIT and Meas_Trig during Busy -> all outputs 0, no Start_Req until new trig; extra trig produces no second transaction.
